vga_sync_gen: RTL and testbench
===============================

Name: vga_sync_gen

Overview:
- Upstream timing stage for the clock/calendar display renderer.
- Divides the 100 MHz board clock into a 25 MHz pixel tick and runs the 640x480@60 horizontal and vertical counters.
- Drives PIX_X/PIX_Y to the renderer and takes back its 8-bit colour.
- Emits pipeline-aligned HSYNC, VSYNC and VIDEO_ON plus a blanked RGB byte to the VGA connector.

Parameters:
- TICK_DIV, 4, CLK_NEXYS cycles per pixel (integer ≥ 2).
- H_DISPLAY, 640, visible pixels per line.
- H_FRONT, 16, horizontal front porch in pixels.
- H_SYNC, 96, horizontal sync width in pixels.
- H_BACK, 48, horizontal back porch in pixels.
- V_DISPLAY, 480, visible lines per frame.
- V_FRONT, 10, vertical front porch in lines.
- V_SYNC, 2, vertical sync width in lines.
- V_BACK, 33, vertical back porch in lines.

Ports:
- CLK_NEXYS  in  1  board clock, 100 MHz; all state on its rising edge.
- RESET  in  1  asynchronous, active-high reset.
- COLOUR_IN  in  8  renderer colour {R3,G3,B2} for the pixel addressed by PIX_X/PIX_Y during the current pixel period.
- PIX_TICK  out  1  one-CLK_NEXYS-cycle pulse per pixel; also used as the renderer's clk_VGA enable.
- PIX_X  out  10  horizontal counter, 0..H_TOTAL-1.
- PIX_Y  out  10  vertical counter, 0..V_TOTAL-1.
- HSYNC  out  1  horizontal sync, active low.
- VSYNC  out  1  vertical sync, active low.
- VIDEO_ON  out  1  high while the displayed pixel is visible.
- RGB  out  8  COLOUR_IN when visible, else 8'h00.
- FRAME_START  out  1  one-cycle pulse when the counters wrap to (0,0).

Behaviour:
- Derived constants:
  - H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK = 800.
  - V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK = 525.
- Reset, async and immediate:
  - tick counter = 0, PIX_X = 0, PIX_Y = 0.
  - HSYNC = 1, VSYNC = 1.
  - VIDEO_ON = 0, RGB = 8'h00.
  - PIX_TICK = 0, FRAME_START = 0.
- Tick divider:
  - Counter runs 0..TICK_DIV-1 and wraps.
  - PIX_TICK is registered and high for exactly one cycle when the counter is TICK_DIV-1.
  - First PIX_TICK is asserted TICK_DIV cycles after RESET deasserts.
- Counters advance only in cycles where PIX_TICK = 1:
  - PIX_X increments, and wraps from H_TOTAL-1 to 0.
  - PIX_Y increments only on the PIX_X wrap, and wraps from V_TOTAL-1 to 0.
  - No other states exist. Out-of-range values cannot occur, but if reached the counter must return to 0 on the next tick.
- Raw decode, combinational on the current counters:
  - hs_raw = (H_DISPLAY+H_FRONT ≤ PIX_X < H_DISPLAY+H_FRONT+H_SYNC), i.e. 656..751.
  - vs_raw = (V_DISPLAY+V_FRONT ≤ PIX_Y < V_DISPLAY+V_FRONT+V_SYNC), i.e. 490..491.
  - vis_raw = (PIX_X < H_DISPLAY) && (PIX_Y < V_DISPLAY).
- Output stage, updated only in PIX_TICK cycles, sampling pre-increment counters:
  - HSYNC ← ~hs_raw; VSYNC ← ~vs_raw; VIDEO_ON ← vis_raw.
  - RGB ← vis_raw ? COLOUR_IN : 8'h00.
  - Result: HSYNC/VSYNC/VIDEO_ON/RGB lag PIX_X/PIX_Y by exactly one pixel period. This matches the renderer's one-register colour latency.
  - Between ticks all outputs hold.
- FRAME_START is registered, asserted in the same cycle as PIX_TICK when PIX_X = H_TOTAL-1 and PIX_Y = V_TOTAL-1. At the next edge the counters read (0,0).
- Frame period = H_TOTAL·V_TOTAL·TICK_DIV = 1,680,000 CLK_NEXYS cycles.
- Reset mid-frame:
  - All state clears without waiting for a tick.
  - RGB is blanked immediately.
  - No partial FRAME_START pulse is produced.
- Width rule: H_TOTAL and V_TOTAL must each be ≤ 1024. Elaboration fails otherwise.

Test Plan:
- Reset release, COLOUR_IN=8'hFF:
  - PIX_TICK first at cycle 4, then every 4 cycles.
  - PIX_X steps 0,1,2 on ticks; RGB = 8'h00 until the first tick, then 8'hFF.
- Line timing:
  - PIX_X wraps 799→0 and PIX_Y increments in the same cycle.
  - HSYNC low for exactly 96 ticks, beginning on the tick after PIX_X reaches 656.
  - VIDEO_ON falls on the tick after PIX_X = 639.
- Frame timing:
  - VSYNC low for 2 lines (1,600 ticks) starting one pixel after (0,490).
  - FRAME_START pulses once every 1,680,000 cycles.
  - PIX_Y wraps 524→0.
- Blanking, COLOUR_IN held at 8'hA5:
  - RGB = 8'hA5 for exactly 640×480 = 307,200 ticks per frame, else 8'h00.
  - RGB never nonzero while HSYNC or VSYNC is low.
- Alignment, COLOUR_IN = PIX_X[7:0] driven combinationally:
  - On every visible tick, RGB equals the previous PIX_X[7:0]; e.g. RGB = 8'h05 while PIX_X = 6.
- Async reset asserted mid-line at PIX_X=300, PIX_Y=200:
  - Within the same cycle, PIX_X = PIX_Y = 0, HSYNC = VSYNC = 1, VIDEO_ON = 0, RGB = 0.
  - After release, timing restarts as in the first scenario.

Source files
------------

// File: rtl/vga_sync_gen.sv
// vga_sync_gen
//   Pixel-timing front end for the clock/calendar display renderer.
//   Divides the board clock into a one-cycle pixel tick and runs the
//   horizontal and vertical raster counters. The renderer reads these
//   counters and returns a colour, and this block turns that colour into
//   the VGA connector signals: sync pulses, a visible-area flag and a
//   blanked RGB byte.
//
//   Ports:
//     CLK_NEXYS   in   1   board clock; all state changes on its rising edge
//     RESET       in   1   asynchronous, active-high reset
//     COLOUR_IN   in   8   renderer colour {R3,G3,B2} for the pixel at PIX_X/PIX_Y
//     PIX_TICK    out  1   one-cycle pulse per pixel (renderer clock enable)
//     PIX_X       out 10   horizontal counter, 0..H_TOTAL-1
//     PIX_Y       out 10   vertical counter, 0..V_TOTAL-1
//     HSYNC       out  1   horizontal sync, active low
//     VSYNC       out  1   vertical sync, active low
//     VIDEO_ON    out  1   high while the displayed pixel is in the visible area
//     RGB         out  8   COLOUR_IN when visible, otherwise 8'h00
//     FRAME_START out  1   one-cycle pulse in the tick cycle that wraps to (0,0)
//
//   HSYNC, VSYNC, VIDEO_ON and RGB are registered on the pixel tick from the
//   pre-increment counters. They therefore trail PIX_X/PIX_Y by one pixel,
//   which matches the renderer's one-register colour latency.
module vga_sync_gen #(
    parameter int TICK_DIV  = 4,
    parameter int H_DISPLAY = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_DISPLAY = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33
) (
    input  logic       CLK_NEXYS,
    input  logic       RESET,
    input  logic [7:0] COLOUR_IN,
    output logic       PIX_TICK,
    output logic [9:0] PIX_X,
    output logic [9:0] PIX_Y,
    output logic       HSYNC,
    output logic       VSYNC,
    output logic       VIDEO_ON,
    output logic [7:0] RGB,
    output logic       FRAME_START
);

    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int TW      = $clog2(TICK_DIV);

    // Decode thresholds are 11 bits wide so that a total of exactly 1024
    // does not overflow the constant.
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [10:0]   H_LAST    = 11'(H_TOTAL - 1);
    localparam logic [10:0]   V_LAST    = 11'(V_TOTAL - 1);
    localparam logic [10:0]   H_VIS     = 11'(H_DISPLAY);
    localparam logic [10:0]   V_VIS     = 11'(V_DISPLAY);
    localparam logic [10:0]   HS_START  = 11'(H_DISPLAY + H_FRONT);
    localparam logic [10:0]   HS_END    = 11'(H_DISPLAY + H_FRONT + H_SYNC);
    localparam logic [10:0]   VS_START  = 11'(V_DISPLAY + V_FRONT);
    localparam logic [10:0]   VS_END    = 11'(V_DISPLAY + V_FRONT + V_SYNC);

    // The 10-bit counters cannot address a raster larger than 1024.
    if ((H_TOTAL > 1024) || (V_TOTAL > 1024)) begin : g_width_check
        $error("vga_sync_gen: H_TOTAL and V_TOTAL must each be <= 1024");
    end
    if (TICK_DIV < 2) begin : g_div_check
        $error("vga_sync_gen: TICK_DIV must be at least 2");
    end

    logic [TW-1:0] tick_cnt_q, tick_cnt_d;
    logic          pix_tick_q, pix_tick_d;
    logic [9:0]    pix_x_q, pix_x_d;
    logic [9:0]    pix_y_q, pix_y_d;
    logic          hsync_q, hsync_d;
    logic          vsync_q, vsync_d;
    logic          video_on_q, video_on_d;
    logic [7:0]    rgb_q, rgb_d;
    logic          frame_start_q, frame_start_d;

    logic [10:0]   x_ext_s, y_ext_s;
    logic          hs_raw_s, vs_raw_s, vis_raw_s;
    logic          x_wrap_s, y_wrap_s;

    // Raw raster decode from the current (pre-increment) counters.
    always_comb begin
        x_ext_s   = {1'b0, pix_x_q};
        y_ext_s   = {1'b0, pix_y_q};
        hs_raw_s  = (x_ext_s >= HS_START) && (x_ext_s < HS_END);
        vs_raw_s  = (y_ext_s >= VS_START) && (y_ext_s < VS_END);
        vis_raw_s = (x_ext_s < H_VIS) && (y_ext_s < V_VIS);
        // ">=" rather than "==" sends any out-of-range value back to 0.
        x_wrap_s  = (x_ext_s >= H_LAST);
        y_wrap_s  = (y_ext_s >= V_LAST);
    end

    // Next-state logic: tick divider, raster counters and output stage.
    always_comb begin
        tick_cnt_d    = tick_cnt_q;
        pix_x_d       = pix_x_q;
        pix_y_d       = pix_y_q;
        hsync_d       = hsync_q;
        vsync_d       = vsync_q;
        video_on_d    = video_on_q;
        rgb_d         = rgb_q;

        if (tick_cnt_q >= TICK_LAST) begin
            tick_cnt_d = TW'(0);
        end else begin
            tick_cnt_d = tick_cnt_q + TW'(1);
        end

        // The tick flop is set from the last divider count, so the first
        // tick appears TICK_DIV cycles after reset is released.
        pix_tick_d = (tick_cnt_q == TICK_LAST);

        // FRAME_START rises together with the tick that carries the last
        // raster position, so (0,0) appears on the following edge.
        frame_start_d = pix_tick_d && (x_ext_s == H_LAST) && (y_ext_s == V_LAST);

        if (pix_tick_q) begin
            if (x_wrap_s) begin
                pix_x_d = 10'd0;
                if (y_wrap_s) begin
                    pix_y_d = 10'd0;
                end else begin
                    pix_y_d = pix_y_q + 10'd1;
                end
            end else begin
                pix_x_d = pix_x_q + 10'd1;
                pix_y_d = pix_y_q;
            end
            hsync_d    = ~hs_raw_s;
            vsync_d    = ~vs_raw_s;
            video_on_d = vis_raw_s;
            rgb_d      = vis_raw_s ? COLOUR_IN : 8'h00;
        end else begin
            pix_x_d    = pix_x_q;
            pix_y_d    = pix_y_q;
            hsync_d    = hsync_q;
            vsync_d    = vsync_q;
            video_on_d = video_on_q;
            rgb_d      = rgb_q;
        end
    end

    // State registers; reset clears everything immediately, including RGB.
    always_ff @(posedge CLK_NEXYS or posedge RESET) begin
        if (RESET) begin
            tick_cnt_q    <= TW'(0);
            pix_tick_q    <= 1'b0;
            pix_x_q       <= 10'd0;
            pix_y_q       <= 10'd0;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            video_on_q    <= 1'b0;
            rgb_q         <= 8'h00;
            frame_start_q <= 1'b0;
        end else begin
            tick_cnt_q    <= tick_cnt_d;
            pix_tick_q    <= pix_tick_d;
            pix_x_q       <= pix_x_d;
            pix_y_q       <= pix_y_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            video_on_q    <= video_on_d;
            rgb_q         <= rgb_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign PIX_TICK    = pix_tick_q;
    assign PIX_X       = pix_x_q;
    assign PIX_Y       = pix_y_q;
    assign HSYNC       = hsync_q;
    assign VSYNC       = vsync_q;
    assign VIDEO_ON    = video_on_q;
    assign RGB         = rgb_q;
    assign FRAME_START = frame_start_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen
//   Self-checking bench for vga_sync_gen. Instance A uses the default
//   640x480 timing for reset, tick, line, alignment and mid-line reset
//   scenarios. Instance B uses a tiny raster so that several whole frames fit
//   in a short run for the frame and blanking scenarios. Expected outputs are
//   computed in closed form from the number of clock edges since reset release.
module tb_vga_sync_gen;

    typedef struct {
        int tdiv; int hd; int hf; int hs; int hb; int vd; int vf; int vs; int vb;
    } tp_t;

    tp_t PA, PB;

    logic       clk = 1'b0;
    logic       rst_a, rst_b;
    logic [7:0] colour_a, colour_b, col_rand_a;
    int         mode_a, mode_b;   // 0 random, 1 fixed, 2 (A only) colour = PIX_X[7:0]
    logic [7:0] fix_a, fix_b;

    logic       PIX_TICK_a, HSYNC_a, VSYNC_a, VIDEO_ON_a, FRAME_START_a;
    logic [9:0] PIX_X_a, PIX_Y_a;
    logic [7:0] RGB_a;
    logic       PIX_TICK_b, HSYNC_b, VSYNC_b, VIDEO_ON_b, FRAME_START_b;
    logic [9:0] PIX_X_b, PIX_Y_b;
    logic [7:0] RGB_b;

    logic [32:0] obs_a, obs_b, e;

    longint     n_a, n_b;          // clock edges since reset release
    logic       pend_a, pend_b;    // the cycle now running is a pixel tick
    logic [7:0] pcol_a, pcol_b;    // colour presented during that tick
    logic [7:0] latch_a, latch_b;  // colour of the most recent completed tick
    int         n_total, n_pass;

    always #5 clk = ~clk;

    assign colour_a = (mode_a == 2) ? PIX_X_a[7:0] : col_rand_a;
    assign obs_a = {PIX_TICK_a, PIX_X_a, PIX_Y_a, HSYNC_a, VSYNC_a, VIDEO_ON_a, RGB_a, FRAME_START_a};
    assign obs_b = {PIX_TICK_b, PIX_X_b, PIX_Y_b, HSYNC_b, VSYNC_b, VIDEO_ON_b, RGB_b, FRAME_START_b};

    vga_sync_gen dut_a (
        .CLK_NEXYS(clk), .RESET(rst_a), .COLOUR_IN(colour_a),
        .PIX_TICK(PIX_TICK_a), .PIX_X(PIX_X_a), .PIX_Y(PIX_Y_a),
        .HSYNC(HSYNC_a), .VSYNC(VSYNC_a), .VIDEO_ON(VIDEO_ON_a),
        .RGB(RGB_a), .FRAME_START(FRAME_START_a)
    );

    vga_sync_gen #(
        .TICK_DIV(3), .H_DISPLAY(10), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
        .V_DISPLAY(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(2)
    ) dut_b (
        .CLK_NEXYS(clk), .RESET(rst_b), .COLOUR_IN(colour_b),
        .PIX_TICK(PIX_TICK_b), .PIX_X(PIX_X_b), .PIX_Y(PIX_Y_b),
        .HSYNC(HSYNC_b), .VSYNC(VSYNC_b), .VIDEO_ON(VIDEO_ON_b),
        .RGB(RGB_b), .FRAME_START(FRAME_START_b)
    );

    // ---------------- reference model ----------------
    function automatic longint ht_of(tp_t p);
        return p.hd + p.hf + p.hs + p.hb;
    endfunction

    function automatic longint vt_of(tp_t p);
        return p.vd + p.vf + p.vs + p.vb;
    endfunction

    // Ticks whose effect has landed after n edges: tick cycles are n = tdiv,
    // 2*tdiv, ... and each one takes effect on the following edge.
    function automatic longint ticks_of(tp_t p, longint n);
        return (n <= p.tdiv) ? 0 : (n - 1) / p.tdiv;
    endfunction

    function automatic bit tick_at(tp_t p, longint n);
        return (n >= p.tdiv) && ((n % p.tdiv) == 0);
    endfunction

    function automatic longint pos_of(tp_t p, longint n);
        return ticks_of(p, n) % (ht_of(p) * vt_of(p));
    endfunction

    function automatic logic [32:0] exp_vec(tp_t p, longint n, logic [7:0] latch);
        longint ht, fr, tk, pos, q, qx, qy;
        logic t, hs, vs, von, fs;
        logic [7:0] rgb;
        ht  = ht_of(p);
        fr  = ht * vt_of(p);
        tk  = ticks_of(p, n);
        pos = tk % fr;
        t   = tick_at(p, n);
        hs  = 1'b1; vs = 1'b1; von = 1'b0; rgb = 8'h00;
        if (tk > 0) begin
            q   = (tk - 1) % fr;
            qx  = q % ht;
            qy  = q / ht;
            hs  = !((qx >= p.hd + p.hf) && (qx < p.hd + p.hf + p.hs));
            vs  = !((qy >= p.vd + p.vf) && (qy < p.vd + p.vf + p.vs));
            von = (qx < p.hd) && (qy < p.vd);
            rgb = von ? latch : 8'h00;
        end
        fs = t && (pos == fr - 1);
        return {t, 10'(pos % ht), 10'(pos / ht), hs, vs, von, rgb, fs};
    endfunction

    // ---------------- stimulus plumbing ----------------
    task automatic prime();
        col_rand_a = (mode_a == 1) ? fix_a : 8'($urandom);
        colour_b   = (mode_b == 1) ? fix_b : 8'($urandom);
        pend_a     = !rst_a && tick_at(PA, n_a);
        pcol_a     = (mode_a == 2) ? 8'(pos_of(PA, n_a) % ht_of(PA)) : col_rand_a;
        pend_b     = !rst_b && tick_at(PB, n_b);
        pcol_b     = colour_b;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (!rst_a) begin
            n_a++;
            if (pend_a) latch_a = pcol_a;
        end
        if (!rst_b) begin
            n_b++;
            if (pend_b) latch_b = pcol_b;
        end
        prime();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        #2;
        rst_a = 1'b1; rst_b = 1'b1; n_a = 0; n_b = 0;
        prime();
        #1;
        for (int i = 0; i < 4; i++) begin
            e = exp_vec(PA, n_a, latch_a);
            n_total++;
            if (obs_a !== e) $display("FAIL reset_a cyc=%0d got %h exp %h", i, obs_a, e);
            else n_pass++;
            e = exp_vec(PB, n_b, latch_b);
            n_total++;
            if (obs_b !== e) $display("FAIL reset_b cyc=%0d got %h exp %h", i, obs_b, e);
            else n_pass++;
            if (i < 3) step();
        end
        rst_a = 1'b0; rst_b = 1'b0;
        prime();
    endtask

    task automatic test_tick_start();
        int ticks;
        ticks = 0;
        mode_a = 1; fix_a = 8'hFF;
        prime();
        for (int i = 0; i < 60; i++) begin
            step();
            e = exp_vec(PA, n_a, latch_a);
            n_total++;
            if (obs_a !== e) begin
                if (n_total - n_pass < 40) $display("FAIL tick_start n=%0d got %h exp %h", n_a, obs_a, e);
            end else n_pass++;
            if (n_a == 4) begin
                n_total++;
                if (PIX_TICK_a !== 1'b1) $display("FAIL first_tick got %b exp 1", PIX_TICK_a);
                else n_pass++;
            end
            if (PIX_TICK_a) ticks++;
        end
        n_total++;
        if (ticks != 15) $display("FAIL tick_count got %0d exp 15", ticks);
        else n_pass++;
    endtask

    task automatic test_line_timing();
        int hs_low;
        hs_low = 0;
        mode_a = 0;
        prime();
        for (int i = 0; i < 8000 && ticks_of(PA, n_a) < 1700; i++) begin
            step();
            e = exp_vec(PA, n_a, latch_a);
            n_total++;
            if (obs_a !== e) begin
                if (n_total - n_pass < 40) $display("FAIL line n=%0d got %h exp %h", n_a, obs_a, e);
            end else n_pass++;
            if (PIX_TICK_a && (pos_of(PA, n_a) / ht_of(PA) == 1) && !HSYNC_a) hs_low++;
        end
        n_total++;
        if (ticks_of(PA, n_a) < 1700) $display("FAIL line_timeout got %0d ticks exp 1700", ticks_of(PA, n_a));
        else n_pass++;
        n_total++;
        if (hs_low != PA.hs) $display("FAIL hsync_width got %0d exp %0d", hs_low, PA.hs);
        else n_pass++;
    endtask

    task automatic test_frame_timing();
        longint last, per;
        int pulses, vs_low;
        pulses = 0; vs_low = 0; last = 0;
        per = PB.tdiv * ht_of(PB) * vt_of(PB);
        mode_b = 0;
        prime();
        for (int i = 0; i < 2000; i++) begin
            step();
            e = exp_vec(PB, n_b, latch_b);
            n_total++;
            if (obs_b !== e) begin
                if (n_total - n_pass < 40) $display("FAIL frame n=%0d got %h exp %h", n_b, obs_b, e);
            end else n_pass++;
            if (FRAME_START_b) begin
                if (pulses > 0) begin
                    n_total++;
                    if (n_b - last != per) $display("FAIL frame_period got %0d exp %0d", n_b - last, per);
                    else n_pass++;
                    n_total++;
                    if (vs_low != PB.vs * ht_of(PB)) $display("FAIL vsync_width got %0d exp %0d", vs_low, PB.vs * ht_of(PB));
                    else n_pass++;
                end
                last = n_b; pulses++; vs_low = 0;
            end
            if (pulses > 0 && PIX_TICK_b && !VSYNC_b) vs_low++;
        end
        n_total++;
        if (pulses < 3) $display("FAIL frame_count got %0d exp >=3", pulses);
        else n_pass++;
    endtask

    task automatic test_blanking();
        int pulses, vis, viol;
        pulses = 0; vis = 0; viol = 0;
        mode_b = 1; fix_b = 8'hA5;
        prime();
        for (int i = 0; i < 2000 && pulses < 3; i++) begin
            step();
            e = exp_vec(PB, n_b, latch_b);
            n_total++;
            if (obs_b !== e) begin
                if (n_total - n_pass < 40) $display("FAIL blank n=%0d got %h exp %h", n_b, obs_b, e);
            end else n_pass++;
            if (FRAME_START_b) begin
                if (pulses > 0) begin
                    n_total++;
                    if (vis != PB.hd * PB.vd) $display("FAIL blank_count got %0d exp %0d", vis, PB.hd * PB.vd);
                    else n_pass++;
                end
                vis = 0; pulses++;
            end
            if (pulses > 0 && PIX_TICK_b && RGB_b == 8'hA5) vis++;
            if (RGB_b != 8'h00 && (!HSYNC_b || !VSYNC_b)) viol++;
        end
        n_total++;
        if (pulses < 3) $display("FAIL blank_timeout got %0d pulses exp 3", pulses);
        else n_pass++;
        n_total++;
        if (viol != 0) $display("FAIL blank_sync got %0d exp 0", viol);
        else n_pass++;
    endtask

    task automatic test_alignment();
        bit seen;
        longint pos;
        seen = 0;
        mode_a = 2;
        prime();
        for (int i = 0; i < 3400; i++) begin
            step();
            e = exp_vec(PA, n_a, latch_a);
            n_total++;
            if (obs_a !== e) begin
                if (n_total - n_pass < 40) $display("FAIL align n=%0d got %h exp %h", n_a, obs_a, e);
            end else n_pass++;
            pos = pos_of(PA, n_a);
            if (!seen && (pos % ht_of(PA) == 6) && (pos / ht_of(PA) < PA.vd)) begin
                seen = 1;
                n_total++;
                if (RGB_a !== 8'h05) $display("FAIL align_x6 got %h exp 05", RGB_a);
                else n_pass++;
            end
        end
        n_total++;
        if (!seen) $display("FAIL align_timeout got 0 exp 1");
        else n_pass++;
    endtask

    task automatic test_async_reset();
        mode_a = 0;
        prime();
        for (int i = 0; i < 3400 && (pos_of(PA, n_a) % ht_of(PA) != 300); i++) step();
        n_total++;
        if (pos_of(PA, n_a) % ht_of(PA) != 300) $display("FAIL async_wait got %0d exp 300", pos_of(PA, n_a) % ht_of(PA));
        else n_pass++;
        n_total++;
        if (PIX_X_a !== 10'd300) $display("FAIL async_pre_x got %0d exp 300", PIX_X_a);
        else n_pass++;
        rst_a = 1'b1; n_a = 0;
        prime();
        #1;
        e = exp_vec(PA, n_a, latch_a);
        n_total++;
        if (obs_a !== e) $display("FAIL async_reset got %h exp %h", obs_a, e);
        else n_pass++;
        step();
        step();
        rst_a = 1'b0;
        mode_a = 1; fix_a = 8'hFF;
        prime();
        for (int i = 0; i < 30; i++) begin
            step();
            e = exp_vec(PA, n_a, latch_a);
            n_total++;
            if (obs_a !== e) begin
                if (n_total - n_pass < 40) $display("FAIL restart n=%0d got %h exp %h", n_a, obs_a, e);
            end else n_pass++;
            if (n_a == 4) begin
                n_total++;
                if (PIX_TICK_a !== 1'b1) $display("FAIL restart_tick got %b exp 1", PIX_TICK_a);
                else n_pass++;
            end
        end
    endtask

    task automatic test_random_reset();
        int run;
        mode_b = 0;
        prime();
        for (int k = 0; k < 3; k++) begin
            run = $urandom_range(20, 400);
            for (int i = 0; i < run; i++) begin
                step();
                e = exp_vec(PB, n_b, latch_b);
                n_total++;
                if (obs_b !== e) begin
                    if (n_total - n_pass < 40) $display("FAIL rand_run n=%0d got %h exp %h", n_b, obs_b, e);
                end else n_pass++;
            end
            #($urandom_range(0, 6));
            rst_b = 1'b1; n_b = 0;
            prime();
            #1;
            e = exp_vec(PB, n_b, latch_b);
            n_total++;
            if (obs_b !== e) $display("FAIL rand_reset got %h exp %h", obs_b, e);
            else n_pass++;
            run = $urandom_range(1, 3);
            for (int i = 0; i < run; i++) step();
            rst_b = 1'b0;
            prime();
        end
    endtask

    initial begin
        PA = '{4, 640, 16, 96, 48, 480, 10, 2, 33};
        PB = '{3, 10, 2, 3, 2, 6, 1, 2, 2};
        n_total = 0; n_pass = 0;
        mode_a = 0; mode_b = 0; fix_a = 8'h00; fix_b = 8'h00;
        rst_a = 1'b0; rst_b = 1'b0;
        n_a = 0; n_b = 0; latch_a = 8'h00; latch_b = 8'h00;
        prime();
        test_reset();
        test_tick_start();
        test_line_timing();
        test_frame_timing();
        test_blanking();
        test_alignment();
        test_async_reset();
        test_random_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
